// File: rtl/icache_pkg.sv
`default_nettype none
// icache_pkg: AHB-Lite constants, FSM encoding and geometry helpers shared by the icache_ahb slice.
package icache_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam logic [2:0] HSIZE_WORD       = 3'b010;
  localparam logic [3:0] HPROT_FETCH_PRIV = 4'b0010;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOOKUP = 2'd1;
  localparam logic [1:0] ST_REFILL = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  function automatic int tag_width(input int addr_w, input int log2_lines, input int log2_words);
    return addr_w - log2_lines - log2_words - 2;
  endfunction

  function automatic logic [2:0] burst_for(input int log2_words);
    case (log2_words)
      2:       return HBURST_INCR4;
      3:       return HBURST_INCR8;
      default: return HBURST_INCR16;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/icache_line_ram.sv
`default_nettype none
// icache_line_ram: register-array line store with tags; registered read by index, full-line write.
module icache_line_ram
  import icache_pkg::*;
#(
  parameter int LOG2_NUM_LINES = 5,
  parameter int LINE_BITS      = 256,
  parameter int TAG_WIDTH      = 22
) (
  input  logic                      clk,
  input  logic [LOG2_NUM_LINES-1:0] rd_idx,
  output logic [LINE_BITS-1:0]      rd_line,
  output logic [TAG_WIDTH-1:0]      rd_tag,
  input  logic                      wr_en,
  input  logic [LOG2_NUM_LINES-1:0] wr_idx,
  input  logic [LINE_BITS-1:0]      wr_line,
  input  logic [TAG_WIDTH-1:0]      wr_tag
);

  logic [LINE_BITS-1:0] line_mem [1<<LOG2_NUM_LINES];
  logic [TAG_WIDTH-1:0] tag_mem  [1<<LOG2_NUM_LINES];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      line_mem[wr_idx] <= wr_line;
      tag_mem[wr_idx]  <= wr_tag;
    end
    rd_line <= line_mem[rd_idx];
    rd_tag  <= tag_mem[rd_idx];
  end

endmodule
`default_nettype wire

// File: rtl/icache_ahb.sv
`default_nettype none
// icache_ahb: direct-mapped read-only instruction cache with AHB-Lite incrementing-burst refill.
// Defining ICACHE_STATS_EN adds the hit_cnt/miss_cnt lookup counters.
module icache_ahb
  import icache_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int WORD_WIDTH      = 32,
  parameter int LOG2_LINE_WORDS = 3,
  parameter int LOG2_NUM_LINES  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  ready,
  output logic                  valid,
  output logic [WORD_WIDTH-1:0] data,
  output logic                  err,
  input  logic                  flush,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic [2:0]            HBURST,
  output logic [2:0]            HSIZE,
  output logic [3:0]            HPROT,
  output logic                  HWRITE,
  input  logic [WORD_WIDTH-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt
`endif
);

  localparam int LINE_WORDS = 1 << LOG2_LINE_WORDS;
  localparam int NUM_LINES  = 1 << LOG2_NUM_LINES;
  localparam int TAG_WIDTH  = tag_width(ADDR_WIDTH, LOG2_NUM_LINES, LOG2_LINE_WORDS);
  localparam int LINE_BITS  = LINE_WORDS * WORD_WIDTH;
  localparam int IDX_LSB    = LOG2_LINE_WORDS + 2;
  localparam int TAG_LSB    = IDX_LSB + LOG2_NUM_LINES;
  localparam logic [LOG2_LINE_WORDS-1:0] CNT_LAST = '1;
  localparam logic [LOG2_LINE_WORDS-1:0] CNT_ONE  = {{(LOG2_LINE_WORDS-1){1'b0}}, 1'b1};

  if (LOG2_LINE_WORDS < 2 || LOG2_LINE_WORDS > 4 || WORD_WIDTH != 32) begin : g_bad_geometry
    $error("icache_ahb: LINE_WORDS must be 4, 8 or 16 and WORD_WIDTH must be 32");
  end

  logic [1:0]                 state;
  logic [ADDR_WIDTH-1:0]      req_addr;
  logic [NUM_LINES-1:0]       line_valid;
  logic [1:0]                 htrans_r;
  logic [ADDR_WIDTH-1:0]      haddr_r;
  logic [LOG2_LINE_WORDS-1:0] addr_cnt;
  logic [LOG2_LINE_WORDS-1:0] data_cnt;
  logic                       dphase;
  logic                       flushed;
  logic [WORD_WIDTH-1:0]      data_r;
  logic                       err_r;
  logic [LINE_BITS-1:0]       line_buf;
  logic [LINE_BITS-1:0]       fill_line;
  logic [LINE_BITS-1:0]       rd_line;
  logic [TAG_WIDTH-1:0]       rd_tag;
  logic [TAG_WIDTH-1:0]       req_tag;
  logic [LOG2_NUM_LINES-1:0]  req_idx;
  logic [LOG2_LINE_WORDS-1:0] req_off;
  logic                       hit;
  logic                       fill_done;
  logic                       unused_bits;

  assign req_tag     = req_addr[ADDR_WIDTH-1:TAG_LSB];
  assign req_idx     = req_addr[TAG_LSB-1:IDX_LSB];
  assign req_off     = req_addr[IDX_LSB-1:2];
  assign unused_bits = ^req_addr[1:0];

  // A flush in the lookup cycle wins over a stale valid bit.
  assign hit       = line_valid[req_idx] & ~flush & (rd_tag == req_tag);
  assign fill_done = (state == ST_REFILL) & dphase & HREADY & ~HRESP & (data_cnt == CNT_LAST) & ~rst;

  always_comb begin
    fill_line = line_buf;
    fill_line[data_cnt*WORD_WIDTH +: WORD_WIDTH] = HRDATA;
  end

  // Reading on every cycle from the live address makes the line available during LOOKUP.
  icache_line_ram #(
    .LOG2_NUM_LINES(LOG2_NUM_LINES),
    .LINE_BITS     (LINE_BITS),
    .TAG_WIDTH     (TAG_WIDTH)
  ) u_line_ram (
    .clk    (clk),
    .rd_idx (addr[TAG_LSB-1:IDX_LSB]),
    .rd_line(rd_line),
    .rd_tag (rd_tag),
    .wr_en  (fill_done),
    .wr_idx (req_idx),
    .wr_line(fill_line),
    .wr_tag (req_tag)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      req_addr   <= '0;
      line_valid <= '0;
      htrans_r   <= HTRANS_IDLE;
      haddr_r    <= '0;
      addr_cnt   <= '0;
      data_cnt   <= '0;
      dphase     <= 1'b0;
      flushed    <= 1'b0;
      data_r     <= '0;
      err_r      <= 1'b0;
    end else begin
      if (flush) line_valid <= '0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            req_addr <= addr;
            state    <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (hit) begin
            data_r <= rd_line[req_off*WORD_WIDTH +: WORD_WIDTH];
            err_r  <= 1'b0;
            state  <= ST_RESP;
          end else begin
            haddr_r  <= {req_tag, req_idx, {IDX_LSB{1'b0}}};
            htrans_r <= HTRANS_NONSEQ;
            addr_cnt <= '0;
            data_cnt <= '0;
            dphase   <= 1'b0;
            flushed  <= 1'b0;
            state    <= ST_REFILL;
          end
        end
        ST_REFILL: begin
          if (flush) flushed <= 1'b1;
          if (dphase && HRESP) begin
            // Two-cycle error: drop the pending address, then finish on the second cycle.
            htrans_r <= HTRANS_IDLE;
            if (HREADY) begin
              dphase <= 1'b0;
              data_r <= '0;
              err_r  <= 1'b1;
              state  <= ST_RESP;
            end
          end else if (HREADY) begin
            if (dphase) begin
              line_buf <= fill_line;
              data_cnt <= data_cnt + CNT_ONE;
              if (data_cnt == CNT_LAST) begin
                data_r <= fill_line[req_off*WORD_WIDTH +: WORD_WIDTH];
                err_r  <= 1'b0;
                state  <= ST_RESP;
                if (!flushed && !flush) line_valid[req_idx] <= 1'b1;
              end
            end
            if (htrans_r != HTRANS_IDLE) begin
              dphase   <= 1'b1;
              addr_cnt <= addr_cnt + CNT_ONE;
              if (addr_cnt == CNT_LAST) begin
                htrans_r <= HTRANS_IDLE;
              end else begin
                htrans_r <= HTRANS_SEQ;
                haddr_r  <= haddr_r + ADDR_WIDTH'(4);
              end
            end else begin
              dphase <= 1'b0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == ST_LOOKUP) begin
      if (hit) hit_cnt <= hit_cnt + 32'd1;
      else     miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

  // Reset forces the bus and core outputs quiet within the same cycle, even mid-refill.
  assign ready  = ~rst & (state == ST_IDLE);
  assign valid  = ~rst & (state == ST_RESP);
  assign data   = rst ? '0 : data_r;
  assign err    = ~rst & err_r;
  assign HTRANS = rst ? HTRANS_IDLE : htrans_r;
  assign HADDR  = rst ? '0 : haddr_r;
  assign HBURST = burst_for(LOG2_LINE_WORDS);
  assign HSIZE  = HSIZE_WORD;
  assign HPROT  = HPROT_FETCH_PRIV;
  assign HWRITE = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_icache_ahb.sv
`default_nettype none
// tb_icache_ahb: directed vector table, AHB slave model and randomized fetches against a cache model.
module tb_icache_ahb;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] addr = 32'h0;
  logic        ready, valid, err;
  logic [31:0] data;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HBURST, HSIZE;
  logic [3:0]  HPROT;
  logic        HWRITE;
  logic [31:0] HRDATA = 32'h0;
  logic        HREADY = 1'b1;
  logic        HRESP = 1'b0;

  int passed = 0;
  int total  = 0;

  icache_ahb dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .ready(ready), .valid(valid),
    .data(data), .err(err), .flush(flush), .HADDR(HADDR), .HTRANS(HTRANS),
    .HBURST(HBURST), .HSIZE(HSIZE), .HPROT(HPROT), .HWRITE(HWRITE),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
    $fatal(1, "watchdog expired");
  end

  // Backing memory: word at 0x100+4n reads 0x1000+n, unique per word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000 + (a >> 2) - 32'h40;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  // ---------------- AHB slave model ----------------
  logic        pend = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  int          beat = 0, wait_beat = -1, wait_cycles = 2, err_beat = -1;
  int          wait_left = 0, err_stage = 0, nonseq_cnt = 0;
  logic        stall_prev = 1'b0;
  logic [31:0] stall_addr;
  logic [1:0]  stall_trans;
  logic [31:0] log_addr[$];
  logic [1:0]  log_trans[$];

  always @(negedge clk) begin
    if (stall_prev) begin
      check("stall_haddr", HADDR, stall_addr);
      check("stall_htrans", {30'b0, HTRANS}, {30'b0, stall_trans});
    end
    stall_prev = 1'b0;
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = 32'hDEAD_BEEF;
    if (pend) begin
      if (err_stage == 1) begin
        HREADY = 1'b0; HRESP = 1'b1; err_stage = 2;
      end else if (err_stage == 2) begin
        HRESP = 1'b1; err_stage = 0;
        check("err_cancel_htrans", {30'b0, HTRANS}, {30'b0, T_IDLE});
      end else if (wait_left > 0) begin
        HREADY = 1'b0; wait_left--;
      end else begin
        HRDATA = mem_word(pend_addr);
      end
    end
    if (!HREADY && HTRANS[1] && err_stage != 2 && !rst) begin
      stall_prev = 1'b1; stall_addr = HADDR; stall_trans = HTRANS;
    end
    if (HREADY) begin
      if (HTRANS[1]) begin
        beat = (HTRANS == T_NONSEQ) ? 0 : beat + 1;
        if (HTRANS == T_NONSEQ) nonseq_cnt++;
        log_addr.push_back(HADDR);
        log_trans.push_back(HTRANS);
        pend      = 1'b1;
        pend_addr = HADDR;
        wait_left = (beat == wait_beat) ? wait_cycles : 0;
        err_stage = (beat == err_beat) ? 1 : 0;
      end else begin
        pend = 1'b0;
      end
    end
  end

  // ---------------- fetch driver ----------------
  task automatic fetch(input logic [31:0] a, input int fc, output logic [31:0] d,
                       output logic e, output int lat, output int bursts);
    int guard = 0;
    int n0;
    while (!ready && guard < 50) begin @(negedge clk); guard++; end
    req = 1'b1; addr = a;
    @(posedge clk);
    n0 = nonseq_cnt;
    @(negedge clk);
    req = 1'b0; addr = $urandom;
    lat = 1;
    while (!valid && lat < 200) begin
      if (lat == fc) flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      lat++;
    end
    d = data; e = err; bursts = nonseq_cnt - n0;
    @(negedge clk);
    check("valid_pulse", {31'b0, valid}, 32'h0);
  endtask

  typedef struct {
    logic [31:0] addr;
    int          flush_cyc;
    int          wait_beat;
    int          err_beat;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
    int          exp_bursts;
  } vec_t;

  vec_t        vecs[15];
  logic        mv[32];
  logic [21:0] mt[32];
  logic [31:0] got_d;
  logic        got_e;
  int          got_lat, got_b;

  initial begin
    vecs[0]  = '{32'h0000_0104, -1, -1, -1, 32'h1001, 1'b0, 11, 1};  // cold miss
    vecs[1]  = '{32'h0000_0118, -1, -1, -1, 32'h1006, 1'b0,  2, 0};  // hit
    vecs[2]  = '{32'h0000_0500, -1, -1, -1, 32'h1100, 1'b0, 11, 1};  // conflict, same index 8
    vecs[3]  = '{32'h0000_0100, -1, -1, -1, 32'h1000, 1'b0, 11, 1};
    vecs[4]  = '{32'h0000_0100, -1, -1, -1, 32'h1000, 1'b0,  2, 0};
    vecs[5]  = '{32'h0000_0204, -1,  3, -1, 32'h1041, 1'b0, 13, 1};  // 2 wait states on beat 3
    vecs[6]  = '{32'h0000_021C, -1, -1, -1, 32'h1047, 1'b0,  2, 0};
    vecs[7]  = '{32'h0000_0300, -1, -1,  2, 32'h0000, 1'b1,  7, 1};  // error on beat 2
    vecs[8]  = '{32'h0000_0300, -1, -1, -1, 32'h1080, 1'b0, 11, 1};
    vecs[9]  = '{32'h0000_0404,  5, -1, -1, 32'h10C1, 1'b0, 11, 1};  // flush during refill
    vecs[10] = '{32'h0000_0404, -1, -1, -1, 32'h10C1, 1'b0, 11, 1};
    vecs[11] = '{32'h0000_0404, -1, -1, -1, 32'h10C1, 1'b0,  2, 0};
    vecs[12] = '{32'h0000_0404,  1, -1, -1, 32'h10C1, 1'b0, 11, 1};  // flush in lookup
    vecs[13] = '{32'h0000_0118, -1, -1, -1, 32'h1006, 1'b0, 11, 1};
    vecs[14] = '{32'h0000_0404, -1, -1, -1, 32'h10C1, 1'b0,  2, 0};

    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, ready}, 32'h0);
    check("rst_valid", {31'b0, valid}, 32'h0);
    check("rst_err", {31'b0, err}, 32'h0);
    check("rst_data", data, 32'h0);
    check("rst_htrans", {30'b0, HTRANS}, {30'b0, T_IDLE});
    check("rst_haddr", HADDR, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {31'b0, ready}, 32'h1);
    check("hburst", {29'b0, HBURST}, 32'h5);
    check("hsize", {29'b0, HSIZE}, 32'h2);
    check("hprot", {28'b0, HPROT}, 32'h2);
    check("hwrite", {31'b0, HWRITE}, 32'h0);

    for (int i = 0; i < 15; i++) begin
      wait_beat = vecs[i].wait_beat;
      err_beat  = vecs[i].err_beat;
      log_addr.delete();
      log_trans.delete();
      fetch(vecs[i].addr, vecs[i].flush_cyc, got_d, got_e, got_lat, got_b);
      check($sformatf("vec%0d_data", i), got_d, vecs[i].exp_data);
      check($sformatf("vec%0d_err", i), {31'b0, got_e}, {31'b0, vecs[i].exp_err});
      check($sformatf("vec%0d_latency", i), got_lat, vecs[i].exp_lat);
      check($sformatf("vec%0d_bursts", i), got_b, vecs[i].exp_bursts);
      if (i == 0) begin
        check("cold_beats", log_addr.size(), 8);
        for (int n = 0; n < 8 && n < log_addr.size(); n++) begin
          check($sformatf("cold_haddr%0d", n), log_addr[n], 32'h100 + 4 * n);
          check($sformatf("cold_htrans%0d", n), {30'b0, log_trans[n]},
                {30'b0, (n == 0) ? T_NONSEQ : T_SEQ});
        end
      end
    end
    wait_beat = -1;
    err_beat  = -1;

    // Randomized fetches against a tag/valid model of the cache.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int j = 0; j < 32; j++) begin mv[j] = 1'b0; mt[j] = '0; end
    for (int k = 0; k < 40; k++) begin
      logic [31:0] a;
      int          fc, ix;
      logic [21:0] tg;
      logic        exp_hit;
      a  = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 5) |
           ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      fc = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 10)) : -1;
      ix = int'((a >> 5) & 32'h1F);
      tg = a[31:10];
      if (fc == 1) begin
        for (int j = 0; j < 32; j++) mv[j] = 1'b0;
      end
      exp_hit = mv[ix] && (mt[ix] == tg);
      if (!exp_hit) begin
        if (fc >= 2) begin
          for (int j = 0; j < 32; j++) mv[j] = 1'b0;
        end else begin
          mv[ix] = 1'b1; mt[ix] = tg;
        end
      end
      fetch(a, fc, got_d, got_e, got_lat, got_b);
      check($sformatf("rnd%0d_data", k), got_d, mem_word(a & ~32'h3));
      check($sformatf("rnd%0d_err", k), {31'b0, got_e}, 32'h0);
      check($sformatf("rnd%0d_latency", k), got_lat, exp_hit ? 2 : 11);
      check($sformatf("rnd%0d_bursts", k), got_b, exp_hit ? 0 : 1);
    end

    // Reset in the middle of a refill.
    req = 1'b1; addr = 32'h0000_0600;
    @(negedge clk);
    req = 1'b0;
    repeat (4) @(negedge clk);
    check("midrefill_busy", {31'b0, HTRANS[1]}, 32'h1);
    rst = 1'b1;
    #1;
    check("midrefill_rst_htrans", {30'b0, HTRANS}, {30'b0, T_IDLE});
    check("midrefill_rst_haddr", HADDR, 32'h0);
    check("midrefill_rst_ready", {31'b0, ready}, 32'h0);
    repeat (2) @(negedge clk);
    check("midrefill_rst_valid", {31'b0, valid}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    fetch(32'h0000_0600, -1, got_d, got_e, got_lat, got_b);
    check("after_rst_data", got_d, 32'h1140);
    check("after_rst_latency", got_lat, 11);
    check("after_rst_bursts", got_b, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/icache_ahb.md
Name: icache_ahb

Overview:
- Parametrised direct-mapped, read-only instruction cache between the core fetch stage and the AHB-Lite bus.
- Generalises the first-generation fetch cache:
  - configurable line count and line width;
  - real AHB incrementing-burst line refill with beat counters;
  - req/ready acceptance handshake;
  - one-cycle response pulse with error flag;
  - single-cycle flush.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- WORD_WIDTH, 32, fetch word and HRDATA width; fixed at 32 in this generation.
- LOG2_LINE_WORDS, 3, log2 of words per line; legal range 2..4, giving LINE_WORDS = 4, 8 or 16.
- LOG2_NUM_LINES, 5, log2 of number of lines.
- Derived localparams:
  - LINE_WORDS = 1<<LOG2_LINE_WORDS
  - NUM_LINES = 1<<LOG2_NUM_LINES
  - TAG_WIDTH = ADDR_WIDTH-LOG2_NUM_LINES-LOG2_LINE_WORDS-2

Ports:
- clk  in  1  single clock; bus and core share it.
- rst  in  1  synchronous, active-high reset.
- req  in  1  fetch request.
- addr  in  ADDR_WIDTH  byte address; addr[1:0] ignored.
- ready  out  1  cache can accept; transfer occurs when req&ready at posedge clk.
- valid  out  1  one-cycle response pulse.
- data  out  WORD_WIDTH  fetched word, meaningful while valid=1.
- err  out  1  bus error for this response, meaningful while valid=1.
- flush  in  1  invalidate all lines.
- HADDR  out  ADDR_WIDTH  AHB address.
- HTRANS  out  2  IDLE=00, NONSEQ=10, SEQ=11.
- HBURST  out  3  INCR4=011, INCR8=101, INCR16=111, chosen by LINE_WORDS.
- HSIZE  out  3  constant 010, word.
- HPROT  out  4  constant 0010, opcode fetch, privileged.
- HWRITE  out  1  constant 0.
- HRDATA  in  WORD_WIDTH  read data.
- HREADY  in  1  transfer-complete / slave ready.
- HRESP  in  1  slave error response.

Behaviour:
- Address split: offset = addr[LOG2_LINE_WORDS+1:2]; index = next LOG2_NUM_LINES bits; tag = remaining upper bits.
- Reset while rst=1:
  - valid=0, err=0, data=0, ready=0;
  - HTRANS=IDLE, HADDR=0;
  - all line valid bits cleared; state IDLE.
  - ready rises the first cycle after rst falls.
- States: IDLE, LOOKUP, REFILL, RESP.
- IDLE:
  - ready=1.
  - On req&ready, register addr and go to LOOKUP.
- LOOKUP:
  - ready=0.
  - Hit = line valid and stored tag equals tag.
  - Hit: latch word into data, err=0, go to RESP.
  - Miss: go to REFILL.
- Hit latency: valid=1 exactly 2 cycles after the accepting edge. Throughput is one fetch per 3 cycles.
- REFILL, address phase:
  - First beat: HADDR = line-aligned address, HTRANS=NONSEQ.
  - Following beats: HTRANS=SEQ, HADDR += 4.
  - Address counter advances only when HREADY=1.
  - After the last address is accepted, HTRANS=IDLE.
- REFILL, data phase:
  - Data counter captures HRDATA into the line buffer when HREADY=1 in a data phase.
  - When the last beat is captured: write line and tag; set valid bit; latch requested word into data; go to RESP.
  - Miss latency with zero-wait slave: LINE_WORDS+3 cycles from accepting edge to valid.
- Bus error:
  - HRESP=1 with HREADY=0 (first error cycle): drive HTRANS=IDLE next cycle, cancelling the rest of the burst.
  - On the second error cycle (HRESP=1, HREADY=1): go to RESP with err=1 and data=0.
  - Line valid bit stays cleared.
- RESP:
  - valid=1 for one cycle, ready=0; then return to IDLE.
- Flush in IDLE/LOOKUP/RESP: all valid bits clear at the next edge.
  - A flush coincident with a LOOKUP makes that lookup miss.
- Flush during REFILL:
  - The burst runs to completion and the response is delivered normally.
  - The refilled line is written but its valid bit is not set.
  - All other valid bits clear immediately.
- Reset mid-refill: HTRANS=IDLE in the same cycle; the partial line is discarded.
- HBURST for LINE_WORDS outside {4,8,16} is an elaboration error.

Optional Feature:
- Macro ICACHE_STATS_EN.
- Defined:
  - Adds outputs hit_cnt[31:0] and miss_cnt[31:0].
  - Each increments on a LOOKUP hit/miss respectively.
  - Both cleared by rst, not by flush, and wrap at 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package icache_pkg holds:
  - HTRANS/HBURST/HSIZE/HPROT constants;
  - state encoding (IDLE=0, LOOKUP=1, REFILL=2, RESP=3);
  - the TAG_WIDTH derivation function.
- Sub-module icache_line_ram: NUM_LINES x (LINE_WORDS*WORD_WIDTH) register array.
  - Registered read by index.
  - Full-line write.
  - Holds the tag array alongside the data.
  - No vendor RAM macro.

Test Plan:
- Cold miss:
  - Stimulus: after reset, req addr=0x0000_0104, slave returns 0x1000+n on beat n.
  - Response: HADDR 0x100..0x11C, HBURST=101, NONSEQ then 7 SEQ; valid with data=0x1001 at cycle 11 after accept.
- Hit:
  - Stimulus: req 0x0000_0118 after the cold-miss test.
  - Response: no bus activity; valid 2 cycles after accept, data=0x1006.
- Conflict miss:
  - Stimulus: addr 0x0000_0500 (same index 8, different tag), then 0x0000_0100.
  - Response: both miss and each triggers a refill.
- Wait states:
  - Stimulus: HREADY low 2 cycles on beat 3.
  - Response: HADDR/HTRANS held stable while stalled; correct line captured.
- Error:
  - Stimulus: HRESP two-cycle error on beat 2.
  - Response: HTRANS=IDLE after the first error cycle; valid with err=1; the re-request misses again.
- Flush:
  - Stimulus: flush during refill.
  - Response: response delivered; an immediate re-request to the same address misses.
